// File: rtl/pc_unit_if.sv
// Fetch-side bundle of pc_unit: redirect controls in, fetch PC and status out.
// The master drives the redirect controls. The slave is the pc_unit itself.
interface pc_unit_if #(
    parameter int ADDR_W = 10
);
    logic              stall;
    logic              branch_sel;
    logic [31:0]       immediate;
    logic              jump;
    logic              link;
    logic [25:0]       instruction_25;
    logic              jr;
    logic              ret;
    logic [ADDR_W-1:0] jr_target;
    logic [ADDR_W-1:0] counter;
    logic [ADDR_W-1:0] pc_plus4;
    logic              halted;
    logic              ras_empty;
    logic              ras_full;
    logic              ras_underflow;
    logic              misalign_err;

    modport master (
        output stall, branch_sel, immediate, jump, link, instruction_25,
               jr, ret, jr_target,
        input  counter, pc_plus4, halted, ras_empty, ras_full,
               ras_underflow, misalign_err
    );

    modport slave (
        input  stall, branch_sel, immediate, jump, link, instruction_25,
               jr, ret, jr_target,
        output counter, pc_plus4, halted, ras_empty, ras_full,
               ras_underflow, misalign_err
    );
endinterface

// File: rtl/pc_unit.sv
// Program counter / next-PC selector with a sticky halt state and a circular return-address stack.
// Redirect priority is ret > jr > jump > branch > sequential.
module pc_unit #(
    parameter int ADDR_W    = 10,
    parameter int RESET_VEC = 0,
    parameter int PC_LIMIT  = 64,
    parameter int RAS_DEPTH = 4
) (
    input logic     clk,
    input logic     rst,
    pc_unit_if.slave bus
);
    localparam int unsigned       PTR_W = $clog2(RAS_DEPTH);
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(PC_LIMIT);
    localparam logic [PTR_W:0]    FULL  = (PTR_W+1)'(RAS_DEPTH);

    typedef enum logic {RUN, HALT} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] counter_q, counter_d;
    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [ADDR_W-1:0] ras_d [RAS_DEPTH];
    logic [PTR_W-1:0]  sp_q, sp_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              underflow_q, underflow_d;
    logic              misalign_q, misalign_d;

    logic [ADDR_W-1:0] pc_plus4, jump_tgt, raw_tgt, next_pc;
    logic [27:0]       jaddr;
    logic              push, pop, uf_hit, overrun, advance;

    assign pc_plus4 = counter_q + ADDR_W'(4);
    assign jaddr    = {bus.instruction_25, 2'b00};

    // Cores wider than 28 bits keep the current 256 MiB region from pc_plus4.
    if (ADDR_W > 28) begin : g_jump_wide
        assign jump_tgt = {pc_plus4[ADDR_W-1:28], jaddr};
    end else begin : g_jump_narrow
        assign jump_tgt = ADDR_W'(jaddr);
    end

    always_comb begin
        raw_tgt = pc_plus4;
        push    = 1'b0;
        pop     = 1'b0;
        uf_hit  = 1'b0;
        if (bus.ret) begin
            if (count_q != '0) begin
                raw_tgt = ras_q[sp_q - PTR_W'(1)];
                pop     = 1'b1;
            end else begin
                raw_tgt = bus.jr_target;
                uf_hit  = 1'b1;
            end
        end else if (bus.jr) begin
            raw_tgt = bus.jr_target;
        end else if (bus.jump) begin
            raw_tgt = jump_tgt;
            push    = bus.link;
        end else if (bus.branch_sel) begin
            raw_tgt = pc_plus4 + (ADDR_W'($signed(bus.immediate)) << 2);
        end
        next_pc = {raw_tgt[ADDR_W-1:2], 2'b00};
        overrun = next_pc > LIMIT;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (state_q == RUN && !bus.stall && overrun) begin
            state_d = HALT;
        end
    end

    // Datapath and RAS updates happen only on a normal (non-halting) advance.
    always_comb begin
        advance     = (state_q == RUN) && !bus.stall && !overrun;
        counter_d   = counter_q;
        sp_d        = sp_q;
        count_d     = count_q;
        ras_d       = ras_q;
        underflow_d = 1'b0;
        misalign_d  = 1'b0;
        if (advance) begin
            counter_d   = next_pc;
            misalign_d  = |raw_tgt[1:0];
            underflow_d = uf_hit;
            if (push) begin
                ras_d[sp_q] = pc_plus4;
                sp_d        = sp_q + PTR_W'(1);
                if (count_q != FULL) begin
                    count_d = count_q + (PTR_W+1)'(1);
                end
            end else if (pop) begin
                sp_d    = sp_q - PTR_W'(1);
                count_d = count_q - (PTR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counter_q   <= ADDR_W'(RESET_VEC);
            sp_q        <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            counter_q   <= counter_d;
            sp_q        <= sp_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
            misalign_q  <= misalign_d;
        end
    end

    // Stack contents need no reset; an empty count makes them unreachable.
    always_ff @(posedge clk) begin
        ras_q <= ras_d;
    end

    // Output logic.
    always_comb begin
        bus.counter       = counter_q;
        bus.pc_plus4      = pc_plus4;
        bus.halted        = (state_q == HALT);
        bus.ras_empty     = (count_q == '0);
        bus.ras_full      = (count_q == FULL);
        bus.ras_underflow = underflow_q;
        bus.misalign_err  = misalign_q;
    end
endmodule
